// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed little-endian word image into
// instruction RAM and holds the core in reset until the image is complete.
module imem_loader #(
  parameter int   ADDR_W    = 12,
  parameter int   DEPTH     = 4096,
  parameter logic BOOT_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [1:0]        bidx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   wcnt;
  logic              run_en;
  logic              run_nx;
  logic              cpu_rst_q;

  logic              xfer;
  logic [15:0]       hdr_len;
  logic [ADDR_W:0]   wcnt_inc;
  logic              last_word;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_len   = {byte_data, len_lo};
  assign wcnt_inc  = wcnt + 1'b1;
  assign last_word = (16'(wcnt_inc) == len);
  assign run_nx    = run_en | (state == DONE);

  assign byte_ready = (state == HDR0) | (state == HDR1)
                    | (state == DATA);
  assign imem_we    = (state == WRITE);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  assign loading    = (state != IDLE) & (state != ERR);
  assign imem_waddr = addr;
  assign imem_wdata = wdata;
  assign word_count = wcnt;
  assign cpu_rst_n  = cpu_rst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (load_start) state_nx = HDR0;
      HDR0:  if (xfer) state_nx = HDR1;
      HDR1: begin
        if (xfer) begin
          if (hdr_len == 16'd0)
            state_nx = DONE;
          else if ({1'b0, hdr_len} > DEPTH_L)
            state_nx = ERR;
          else
            state_nx = DATA;
        end
      end
      DATA:  if (xfer && bidx == 2'd3) state_nx = WRITE;
      WRITE: state_nx = last_word ? DONE : DATA;
      DONE:  state_nx = IDLE;
      ERR:   if (load_start) state_nx = HDR0;
      default: state_nx = IDLE;
    endcase
  end

  // Core reset is only released when the FSM lands back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en    <= ~BOOT_HOLD;
      cpu_rst_q <= ~BOOT_HOLD;
    end else begin
      run_en    <= run_nx;
      cpu_rst_q <= (state_nx == IDLE) ? run_nx : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo <= '0;
      len    <= '0;
      bidx   <= '0;
      addr   <= '0;
      wdata  <= '0;
      wcnt   <= '0;
    end else begin
      unique case (state)
        IDLE, ERR: begin
          if (load_start) begin
            len  <= '0;
            bidx <= '0;
            addr <= '0;
            wcnt <= '0;
          end
        end
        HDR0: if (xfer) len_lo <= byte_data;
        HDR1: if (xfer) len <= hdr_len;
        DATA: begin
          if (xfer) begin
            wdata[{bidx, 3'b000} +: 8] <= byte_data;
            bidx <= bidx + 2'd1;
          end
        end
        WRITE: begin
          wcnt <= wcnt_inc;
          // Hold on the last word so a full-depth image never wraps.
          if (!last_word) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
